decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
Second pipeline stage of the 5-stage 32-bit MIPS-subset core. It sits directly downstream of the fetch stage and consumes InstructionD/PCPlus4D. It holds the 32x32 register file (written from writeback), decodes control, and sign-extends the immediate. All results are registered into the ID/EX pipeline register, which feeds the execute stage.

Parameters:
BYPASS_EN, 1, 1 = same-cycle writeback data is forwarded to the read ports (write-first); 0 = reads return the old register contents.

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
InstructionD  input  32  instruction from the IF/ID register
PCPlus4D  input  32  PC+4 from the IF/ID register
RegWriteW  input  1  writeback register-write enable
WriteRegW  input  5  writeback destination register
ResultW  input  32  writeback data
FlushE  input  1  synchronous bubble insert into ID/EX
RegWriteE  output  1  register write enable
MemtoRegE  output  1  result comes from memory
MemWriteE  output  1  store enable
BranchE  output  1  beq indicator
ALUControlE  output  3  ALU operation
ALUSrcE  output  1  ALU B operand is the immediate
RegDstE  output  1  destination is rd (1) or rt (0)
RD1E  output  32  rs read data
RD2E  output  32  rt read data
RsE  output  5  instr[25:21]
RtE  output  5  instr[20:16]
RdE  output  5  instr[15:11]
SignImmE  output  32  sign-extended instr[15:0]
PCPlus4E  output  32  PCPlus4D delayed one cycle

Behaviour:
- Reset: on posedge clk with rst=1, all 32 registers are cleared to 0 and every E output goes to 0. rst takes priority over FlushE and over writeback.
- Register file: 32 entries x 32 bits.
  - Write occurs on posedge when RegWriteW=1 and WriteRegW!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Reads are combinational on instr[25:21] and instr[20:16].
  - If BYPASS_EN=1, RegWriteW=1, WriteRegW!=0, and WriteRegW equals the read address, the read port returns ResultW in the same cycle.
- Control decode (opcode instr[31:26]); fields listed as RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, ALUControl:
  - R-type 000000: 1,0,0,0,0,1, ALUControl from funct
  - lw 100011: 1,1,0,0,1,0, 010
  - sw 101011: 0,0,1,0,1,0, 010
  - beq 000100: 0,0,0,1,0,0, 110
  - addi 001000: 1,0,0,0,1,0, 010
  - Any other opcode: all control 0, ALUControl 000 (NOP).
- R-type funct (instr[5:0]):
  - add 100000 -> 010
  - sub 100010 -> 110
  - and 100100 -> 000
  - or 100101 -> 001
  - slt 101010 -> 111
  - Unknown funct: RegWrite=0, ALUControl 000, and other controls are as for R-type.
- SignImm = {{16{instr[15]}}, instr[15:0]}.
- ID/EX register: single-cycle latency. Outputs reflect the InstructionD present before the posedge, and the register updates every cycle (no stall input).
- FlushE=1 (and rst=0): RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE and RegDstE are cleared; ALUControlE is set to 000. Datapath fields (RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCPlus4E) still load normally. The register-file write still occurs.
- All-zero instruction (sll $0 nop, funct 000000) decodes as unknown funct, so no write occurs.
- Simultaneous writeback and read of the same register: behaviour is governed by BYPASS_EN as above. Writeback to $0 while reading $0 returns 0.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs -> all E outputs 0; afterwards, reading any register returns 0.
- Writeback then read: write ResultW=0xDEADBEEF to reg 8; next cycle decode add $10,$8,$9 (0x01095020) -> RD1E=0xDEADBEEF, RegWriteE=1, RegDstE=1, ALUControlE=010, RdE=10.
- Bypass: in the same cycle, write reg 9=0x12345678 and decode sub $3,$9,$9 (0x01291822). BYPASS_EN=1 -> RD1E=RD2E=0x12345678 and ALUControlE=110. BYPASS_EN=0 -> old value (0).
- Immediates: lw $2,-4($1) (0x8C22FFFC) -> SignImmE=0xFFFFFFFC, MemtoRegE=1, ALUSrcE=1, RtE=2. Then sw -> MemWriteE=1, RegWriteE=0. Then beq (0x10220003) -> BranchE=1, ALUControlE=110, SignImmE=3.
- $0 protection: write ResultW=0xFFFFFFFF to reg 0, then decode add $1,$0,$0 -> RD1E=RD2E=0.
- Flush / illegal: FlushE=1 with addi -> all control 0, ALUControlE=000, SignImmE and PCPlus4E still loaded. Opcode 111111 -> all control 0.

Source files
------------

// File: rtl/decode_cycle.sv
// Decode stage of the 5-stage MIPS-subset core: register file, control decode,
// sign extension, and the ID/EX pipeline register that feeds execute.
module decode_cycle #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstructionD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic        ALUSrcE,
    output logic        RegDstE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [31:0] SignImmE,
    output logic [31:0] PCPlus4E
);

    logic [31:0] rf_q [32];

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic        wb_active_s;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [31:0] sign_imm_d;

    logic        reg_write_d;
    logic        mem_to_reg_d;
    logic        mem_write_d;
    logic        branch_d;
    logic        alu_src_d;
    logic        reg_dst_d;
    logic [2:0]  alu_control_d;

    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic        mem_write_q;
    logic        branch_q;
    logic        alu_src_q;
    logic        reg_dst_q;
    logic [2:0]  alu_control_q;
    logic [31:0] rd1_q;
    logic [31:0] rd2_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [31:0] sign_imm_q;
    logic [31:0] pc_plus4_q;

    assign opcode_s    = InstructionD[31:26];
    assign funct_s     = InstructionD[5:0];
    assign rs_s        = InstructionD[25:21];
    assign rt_s        = InstructionD[20:16];
    assign wb_active_s = RegWriteW && (WriteRegW != 5'd0);

    // $0 is hard-wired to zero; optional write-first forwarding of writeback data
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] data;
        if (addr == 5'd0) begin
            data = 32'd0;
        end else if (BYPASS_EN && wb_active_s && (WriteRegW == addr)) begin
            data = ResultW;
        end else begin
            data = rf_q[addr];
        end
        return data;
    endfunction

    // Register file write port, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wb_active_s) begin
            rf_q[WriteRegW] <= ResultW;
        end else begin
            rf_q[WriteRegW] <= rf_q[WriteRegW];
        end
    end

    // Combinational read ports and immediate extension
    always_comb begin
        rd1_d      = read_port(rs_s);
        rd2_d      = read_port(rt_s);
        sign_imm_d = {{16{InstructionD[15]}}, InstructionD[15:0]};
    end

    // Main control decode; unknown R-type funct keeps RegDst but drops the write
    always_comb begin
        reg_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        mem_write_d   = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        reg_dst_d     = 1'b0;
        alu_control_d = 3'b000;
        case (opcode_s)
            6'b000000: begin
                reg_dst_d = 1'b1;
                case (funct_s)
                    6'b100000: begin reg_write_d = 1'b1; alu_control_d = 3'b010; end
                    6'b100010: begin reg_write_d = 1'b1; alu_control_d = 3'b110; end
                    6'b100100: begin reg_write_d = 1'b1; alu_control_d = 3'b000; end
                    6'b100101: begin reg_write_d = 1'b1; alu_control_d = 3'b001; end
                    6'b101010: begin reg_write_d = 1'b1; alu_control_d = 3'b111; end
                    default:   begin reg_write_d = 1'b0; alu_control_d = 3'b000; end
                endcase
            end
            6'b100011: begin
                reg_write_d   = 1'b1;
                mem_to_reg_d  = 1'b1;
                alu_src_d     = 1'b1;
                alu_control_d = 3'b010;
            end
            6'b101011: begin
                mem_write_d   = 1'b1;
                alu_src_d     = 1'b1;
                alu_control_d = 3'b010;
            end
            6'b000100: begin
                branch_d      = 1'b1;
                alu_control_d = 3'b110;
            end
            6'b001000: begin
                reg_write_d   = 1'b1;
                alu_src_d     = 1'b1;
                alu_control_d = 3'b010;
            end
            default: begin
                reg_write_d   = 1'b0;
                alu_control_d = 3'b000;
            end
        endcase
    end

    // ID/EX register; a flush zeroes control but the datapath still loads
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            reg_dst_q     <= 1'b0;
            alu_control_q <= 3'b000;
            rd1_q         <= 32'd0;
            rd2_q         <= 32'd0;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            rd_q          <= 5'd0;
            sign_imm_q    <= 32'd0;
            pc_plus4_q    <= 32'd0;
        end else begin
            if (FlushE) begin
                reg_write_q   <= 1'b0;
                mem_to_reg_q  <= 1'b0;
                mem_write_q   <= 1'b0;
                branch_q      <= 1'b0;
                alu_src_q     <= 1'b0;
                reg_dst_q     <= 1'b0;
                alu_control_q <= 3'b000;
            end else begin
                reg_write_q   <= reg_write_d;
                mem_to_reg_q  <= mem_to_reg_d;
                mem_write_q   <= mem_write_d;
                branch_q      <= branch_d;
                alu_src_q     <= alu_src_d;
                reg_dst_q     <= reg_dst_d;
                alu_control_q <= alu_control_d;
            end
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            rs_q       <= rs_s;
            rt_q       <= rt_s;
            rd_q       <= InstructionD[15:11];
            sign_imm_q <= sign_imm_d;
            pc_plus4_q <= PCPlus4D;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign MemtoRegE   = mem_to_reg_q;
    assign MemWriteE   = mem_write_q;
    assign BranchE     = branch_q;
    assign ALUControlE = alu_control_q;
    assign ALUSrcE     = alu_src_q;
    assign RegDstE     = reg_dst_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign RsE         = rs_q;
    assign RtE         = rt_q;
    assign RdE         = rd_q;
    assign SignImmE    = sign_imm_q;
    assign PCPlus4E    = pc_plus4_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: one forwarding instance and one without
// forwarding share the same stimulus; expected values are hand-computed.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstructionD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        FlushE;

    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E;
    logic [4:0]  RsE, RtE, RdE;

    logic        nb_RegWriteE, nb_MemtoRegE, nb_MemWriteE, nb_BranchE, nb_ALUSrcE, nb_RegDstE;
    logic [2:0]  nb_ALUControlE;
    logic [31:0] nb_RD1E, nb_RD2E, nb_SignImmE, nb_PCPlus4E;
    logic [4:0]  nb_RsE, nb_RtE, nb_RdE;

    int n_tests;
    int n_fail;

    decode_cycle #(.BYPASS_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .InstructionD(InstructionD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RegDstE(RegDstE), .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE),
        .RdE(RdE), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E)
    );

    decode_cycle #(.BYPASS_EN(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .InstructionD(InstructionD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(nb_RegWriteE), .MemtoRegE(nb_MemtoRegE), .MemWriteE(nb_MemWriteE),
        .BranchE(nb_BranchE), .ALUControlE(nb_ALUControlE), .ALUSrcE(nb_ALUSrcE),
        .RegDstE(nb_RegDstE), .RD1E(nb_RD1E), .RD2E(nb_RD2E), .RsE(nb_RsE), .RtE(nb_RtE),
        .RdE(nb_RdE), .SignImmE(nb_SignImmE), .PCPlus4E(nb_PCPlus4E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, RegDst, ALUControl[2:0]}
    typedef struct {
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic        flush;
        logic [8:0]  exp_ctrl;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_nb_rd1;
        logic [31:0] exp_nb_rd2;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
        logic [4:0]  exp_rd;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic wb_en,
                         input logic [4:0] wb_reg, input logic [31:0] wb_data, input logic flush);
        InstructionD = instr;
        PCPlus4D     = pc;
        RegWriteW    = wb_en;
        WriteRegW    = wb_reg;
        ResultW      = wb_data;
        FlushE       = flush;
    endtask

    function automatic logic [8:0] ctrl_of(input logic rw, input logic m2r, input logic mw,
                                           input logic br, input logic as, input logic rdst,
                                           input logic [2:0] alu);
        return {rw, m2r, mw, br, as, rdst, alu};
    endfunction

    initial begin
        logic [31:0] all_out;
        logic [31:0] pc;
        n_tests = 0;
        n_fail  = 0;

        //            instr          wen   wreg   wdata          fl    ctrl          rd1            rd2            nb_rd1         nb_rd2         rs     rt     rd     imm
        vecs[0]  = '{32'h0000_0000, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0, 9'b000001_000, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  5'd0,  32'h0000_0000};
        vecs[1]  = '{32'h0109_5020, 1'b0, 5'd0,  32'h0,         1'b0, 9'b100001_010, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0,         5'd8,  5'd9,  5'd10, 32'h0000_5020};
        vecs[2]  = '{32'h0129_1822, 1'b1, 5'd9,  32'h1234_5678, 1'b0, 9'b100001_110, 32'h1234_5678, 32'h1234_5678, 32'h0,         32'h0,         5'd9,  5'd9,  5'd3,  32'h0000_1822};
        vecs[3]  = '{32'h8C22_FFFC, 1'b1, 5'd1,  32'h0000_0100, 1'b0, 9'b110010_010, 32'h0000_0100, 32'h0,         32'h0,         32'h0,         5'd1,  5'd2,  5'd31, 32'hFFFF_FFFC};
        vecs[4]  = '{32'hAC22_0008, 1'b0, 5'd0,  32'h0,         1'b0, 9'b001010_010, 32'h0000_0100, 32'h0,         32'h0000_0100, 32'h0,         5'd1,  5'd2,  5'd0,  32'h0000_0008};
        vecs[5]  = '{32'h1022_0003, 1'b0, 5'd0,  32'h0,         1'b0, 9'b000100_110, 32'h0000_0100, 32'h0,         32'h0000_0100, 32'h0,         5'd1,  5'd2,  5'd0,  32'h0000_0003};
        vecs[6]  = '{32'h0000_0820, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 9'b100001_010, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  5'd1,  32'h0000_0820};
        vecs[7]  = '{32'h0000_0820, 1'b0, 5'd0,  32'h0,         1'b0, 9'b100001_010, 32'h0,         32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  5'd1,  32'h0000_0820};
        vecs[8]  = '{32'h2025_FFFF, 1'b1, 5'd5,  32'h0000_0077, 1'b1, 9'b000000_000, 32'h0000_0100, 32'h0000_0077, 32'h0000_0100, 32'h0,         5'd1,  5'd5,  5'd31, 32'hFFFF_FFFF};
        vecs[9]  = '{32'h2025_FFFF, 1'b0, 5'd0,  32'h0,         1'b0, 9'b100010_010, 32'h0000_0100, 32'h0000_0077, 32'h0000_0100, 32'h0000_0077, 5'd1,  5'd5,  5'd31, 32'hFFFF_FFFF};
        vecs[10] = '{32'hFC22_1234, 1'b0, 5'd0,  32'h0,         1'b0, 9'b000000_000, 32'h0000_0100, 32'h0,         32'h0000_0100, 32'h0,         5'd1,  5'd2,  5'd2,  32'h0000_1234};
        vecs[11] = '{32'h0025_2024, 1'b0, 5'd0,  32'h0,         1'b0, 9'b100001_000, 32'h0000_0100, 32'h0000_0077, 32'h0000_0100, 32'h0000_0077, 5'd1,  5'd5,  5'd4,  32'h0000_2024};
        vecs[12] = '{32'h0025_2025, 1'b0, 5'd0,  32'h0,         1'b0, 9'b100001_001, 32'h0000_0100, 32'h0000_0077, 32'h0000_0100, 32'h0000_0077, 5'd1,  5'd5,  5'd4,  32'h0000_2025};
        vecs[13] = '{32'h0025_202A, 1'b0, 5'd0,  32'h0,         1'b0, 9'b100001_111, 32'h0000_0100, 32'h0000_0077, 32'h0000_0100, 32'h0000_0077, 5'd1,  5'd5,  5'd4,  32'h0000_202A};

        // Reset, write r3, then reset again (with a competing writeback and flush)
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b1, 5'd3, 32'hAAAA_5555, 1'b0);
        step();
        rst = 1'b1;
        drive(32'h8C22_FFFC, 32'h0000_1234, 1'b1, 5'd3, 32'h5555_AAAA, 1'b1);
        step();
        step();
        all_out = {22'd0, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE, 1'b0};
        check("reset_ctrl", all_out, 32'h0);
        check("reset_rd1", RD1E, 32'h0);
        check("reset_rd2", RD2E, 32'h0);
        check("reset_fields", {17'd0, RsE, RtE, RdE}, 32'h0);
        check("reset_imm", SignImmE, 32'h0);
        check("reset_pc4", PCPlus4E, 32'h0);

        // After reset r3 reads zero even though it had been written
        rst = 1'b0;
        drive(32'h0063_0820, 32'h0000_0040, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("post_reset_r3_rd1", RD1E, 32'h0);
        check("post_reset_r3_rd2", nb_RD2E, 32'h0);
        check("post_reset_pc4", PCPlus4E, 32'h0000_0040);

        for (int i = 0; i < 14; i++) begin
            pc = 32'h0040_0004 + 32'(i) * 32'd4;
            drive(vecs[i].instr, pc, vecs[i].wb_en, vecs[i].wb_reg, vecs[i].wb_data, vecs[i].flush);
            step();
            check($sformatf("v%0d_ctrl", i),
                  {23'd0, ctrl_of(RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE)},
                  {23'd0, vecs[i].exp_ctrl});
            check($sformatf("v%0d_nb_ctrl", i),
                  {23'd0, ctrl_of(nb_RegWriteE, nb_MemtoRegE, nb_MemWriteE, nb_BranchE, nb_ALUSrcE, nb_RegDstE, nb_ALUControlE)},
                  {23'd0, vecs[i].exp_ctrl});
            check($sformatf("v%0d_rd1", i), RD1E, vecs[i].exp_rd1);
            check($sformatf("v%0d_rd2", i), RD2E, vecs[i].exp_rd2);
            check($sformatf("v%0d_nb_rd1", i), nb_RD1E, vecs[i].exp_nb_rd1);
            check($sformatf("v%0d_nb_rd2", i), nb_RD2E, vecs[i].exp_nb_rd2);
            check($sformatf("v%0d_regs", i), {17'd0, RsE, RtE, RdE},
                  {17'd0, vecs[i].exp_rs, vecs[i].exp_rt, vecs[i].exp_rd});
            check($sformatf("v%0d_imm", i), SignImmE, vecs[i].exp_imm);
            check($sformatf("v%0d_pc4", i), PCPlus4E, pc);
        end

        // Flush takes effect on exactly one cycle: the bubble, then normal decode
        drive(32'h8C22_FFFC, 32'h0000_2000, 1'b0, 5'd0, 32'h0, 1'b1);
        step();
        check("flush_lw_ctrl", {31'd0, MemtoRegE | RegWriteE | ALUSrcE}, 32'h0);
        check("flush_lw_imm", SignImmE, 32'hFFFF_FFFC);
        drive(32'h8C22_FFFC, 32'h0000_2004, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        check("unflush_lw_ctrl",
              {23'd0, ctrl_of(RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE)},
              32'h0000_0192);
        check("unflush_lw_pc4", PCPlus4E, 32'h0000_2004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
